// File: rtl/store_buffer.sv
// Circular store buffer between CPU and data memory: stores queue in order,
// drain when the memory write port is free, and younger loads forward from it.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic        ld_hit,
  input  logic [31:0] dm_rd,
  input  logic        drain_en,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  output logic [4:0]  count,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [4:0]    count_q, count_d;
  logic [31:0]   addr_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic          push;
  logic          pop;
  logic [PW-1:0] fwd_idx;

  // Handshake: a store transfers on a rising edge when st_valid & st_ready;
  // st_ready depends on count only, so a full buffer refuses even while draining.
  assign empty    = (count_q == 5'd0);
  assign st_ready = (count_q < 5'(DEPTH));
  assign push     = st_valid & st_ready;
  assign pop      = drain_en & ~empty;
  assign dm_we    = pop;
  assign dm_addr  = empty ? 32'd0 : addr_q[head_q];
  assign dm_wd    = empty ? 32'd0 : wdata_q[head_q];
  assign dm_pc    = empty ? 32'd0 : pc_q[head_q];
  assign count    = count_q;

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: validity is defined purely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q]  <= st_addr;
      wdata_q[tail_q] <= st_wdata;
      pc_q[tail_q]    <= st_pc;
    end
  end

  // Walk oldest to youngest so the last match (the youngest store) wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = dm_rd;
    fwd_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((5'(i) < count_q) && (addr_q[fwd_idx][31:2] == ld_addr[31:2])) begin
        ld_hit  = 1'b1;
        ld_data = wdata_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer contents.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_wdata, st_pc;
  logic        st_ready;
  logic [31:0] ld_addr, ld_data;
  logic        ld_hit;
  logic [31:0] dm_rd;
  logic        drain_en;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wd, dm_pc;
  logic [4:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: buffered stores in program order, index 0 is the oldest.
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_pc(st_pc),
    .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit), .dm_rd(dm_rd),
    .drain_en(drain_en),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] p, input logic [31:0] la,
                       input logic [31:0] rd, input logic dr);
    st_valid = v; st_addr = a; st_wdata = d; st_pc = p;
    ld_addr = la; dm_rd = rd; drain_en = dr;
  endtask

  task automatic check_outputs();
    int          n;
    logic        e_hit;
    logic [31:0] e_data;
    n = exp_q.size();
    e_hit = 1'b0;
    e_data = dm_rd;
    for (int k = n - 1; k >= 0; k--) begin
      if (!e_hit && (exp_addr_q[k] >> 2) == (ld_addr >> 2)) begin
        e_hit = 1'b1;
        e_data = exp_q[k];
      end
    end
    check_eq("count",    32'(count),    32'(n));
    check_eq("empty",    32'(empty),    32'(n == 0));
    check_eq("st_ready", 32'(st_ready), 32'(n < DEPTH));
    check_eq("dm_we",    32'(dm_we),    32'(drain_en && n > 0));
    check_eq("dm_addr",  dm_addr, (n > 0) ? exp_addr_q[0] : 32'd0);
    check_eq("dm_wd",    dm_wd,   (n > 0) ? exp_q[0]      : 32'd0);
    check_eq("dm_pc",    dm_pc,   (n > 0) ? exp_pc_q[0]   : 32'd0);
    check_eq("ld_hit",   32'(ld_hit), 32'(e_hit));
    check_eq("ld_data",  ld_data, e_data);
  endtask

  // Check settled outputs, clock once, then apply the same transfer to the model.
  task automatic tick();
    logic do_pop, do_push;
    #1;
    check_outputs();
    do_pop  = drain_en && exp_q.size() > 0;
    do_push = st_valid && exp_q.size() < DEPTH;
    @(posedge clk);
    if (do_pop) begin
      void'(exp_q.pop_front());
      void'(exp_addr_q.pop_front());
      void'(exp_pc_q.pop_front());
    end
    if (do_push) begin
      exp_q.push_back(st_wdata);
      exp_addr_q.push_back(st_addr);
      exp_pc_q.push_back(st_pc);
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] la, input logic [31:0] rd, input logic dr);
    drive(v, a, d, 32'h1000 + a, la, rd, dr);
    tick();
  endtask

  // Assert reset between edges and check the cleared outputs before any clock.
  task automatic reset_mid_cycle();
    drain_en = 1'b1;
    ld_addr  = 32'h0;
    dm_rd    = 32'h5A5A_0000 | 32'($urandom_range(0, 255));
    #2 reset = 1'b0;
    #1;
    check_eq("rst_count",    32'(count),    32'd0);
    check_eq("rst_dm_we",    32'(dm_we),    32'd0);
    check_eq("rst_empty",    32'(empty),    32'd1);
    check_eq("rst_st_ready", 32'(st_ready), 32'd1);
    check_eq("rst_ld_hit",   32'(ld_hit),   32'd0);
    check_eq("rst_ld_data",  ld_data,       dm_rd);
    check_eq("rst_dm_addr",  dm_addr,       32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    exp_pc_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single push then drain
    cycle(1'b1, 32'h10, 32'hAAAA_0001, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0,  32'h0,         32'h0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0,  32'h0,         32'h0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0,  32'h0,         32'h0, 32'h0, 1'b0);

    // Fill, refused push while draining a full buffer, then accepted
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 32'hB000 + 32'(i), 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h200, 32'hC0DE, 32'h0, 32'h0, 1'b1);
    check_eq("full_refuse_count", 32'(count), 32'(DEPTH - 1));
    cycle(1'b1, 32'h200, 32'hC0DE, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    // No coalescing, youngest match forwards, in-order drain with forwarding from head
    cycle(1'b1, 32'h20, 32'h1111, 32'h0,  32'h0, 1'b0);
    cycle(1'b1, 32'h20, 32'h2222, 32'h0,  32'h0, 1'b0);
    cycle(1'b0, 32'h0,  32'h0,    32'h23, 32'h0, 1'b0);
    check_eq("fwd_youngest", ld_data, 32'h2222);
    cycle(1'b0, 32'h0,  32'h0,    32'h21, 32'h0, 1'b1);
    cycle(1'b0, 32'h0,  32'h0,    32'h22, 32'h0, 1'b1);

    // Same-cycle push is not visible to a load until the next cycle
    cycle(1'b1, 32'h40, 32'h4444, 32'h40, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, 32'h0,  32'h0,    32'h40, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, 32'h0,  32'h0,    32'h40, 32'hDEAD_BEEF, 1'b1);

    // Tail wrap
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h300 + 32'(4 * i), 32'hD000 + 32'(i), 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 4; i < 6; i++) cycle(1'b1, 32'h300 + 32'(4 * i), 32'hD000 + 32'(i), 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Reset with three entries in flight; nothing drains afterwards
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h500 + 32'(4 * i), 32'hE000 + 32'(i), 32'h0, 32'h0, 1'b0);
    reset_mid_cycle();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 32'h500, 32'h77, 1'b1);

    // Random traffic over a small address pool so forwarding hits are frequent
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_mid_cycle();
      end else begin
        drive($urandom_range(0, 99) < 55, 32'($urandom_range(0, 47)), $urandom(),
              $urandom(), 32'($urandom_range(0, 47)), $urandom(),
              $urandom_range(0, 99) < 45);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port st_valid  input  1  CPU presents a store this cycle.
REQ-005 SHALL have port st_addr  input  32  store byte address.
REQ-006 SHALL have port st_wdata  input  32  store word data.
REQ-007 SHALL have port st_pc  input  32  PC of the store instruction.
REQ-008 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port ld_addr  input  32  load byte address from CPU.
REQ-010 SHALL have port ld_data  output  32  load result to CPU.
REQ-011 SHALL have port ld_hit  output  1  ld_data sourced from buffer.
REQ-012 SHALL have port dm_rd  input  32  read data from data memory at ld_addr.
REQ-013 SHALL have port drain_en  input  1  data memory write port free this cycle.
REQ-014 SHALL have ports dm_we (1), dm_addr (32), dm_wd (32), dm_pc (32), all outputs, write port to data memory.
REQ-015 SHALL have ports count  output  5  valid entries; empty  output  1  count==0.

Function
REQ-016 SHALL hold entries {addr, wdata, pc} in a circular FIFO with head, tail pointers wrapping modulo DEPTH.
REQ-017 SHALL drive st_ready = (count < DEPTH); a store with st_valid=1 and st_ready=0 is not recorded and CPU must hold it.
REQ-018 SHALL on rising edge with st_valid & st_ready write entry at tail, advance tail, and increment count.
REQ-019 SHALL drive dm_we = drain_en & !empty combinationally, with dm_addr/dm_wd/dm_pc equal to the head entry.
REQ-020 SHALL drive dm_addr/dm_wd/dm_pc to 0 when empty.
REQ-021 SHALL on rising edge with dm_we=1 advance head and decrement count; data memory commits the same edge.
REQ-022 SHALL on simultaneous push and drain keep count unchanged, advancing both pointers.
REQ-023 SHALL when full refuse a push even if a drain occurs that same cycle (st_ready depends on count only).
REQ-024 SHALL compare only address bits [31:2] for forwarding; stored addr is kept unmodified and passed through unchanged.
REQ-025 SHALL drive ld_hit=1 when any valid entry matches ld_addr[31:2], and ld_data = wdata of the youngest matching entry.
REQ-026 SHALL drive ld_hit=0 and ld_data = dm_rd when no entry matches.
REQ-027 SHALL forward from the head entry even in the cycle it is being drained.
REQ-028 SHALL not forward from a store being pushed in the same cycle; that store becomes visible the next cycle.
REQ-029 SHALL not coalesce: repeated stores to one word occupy separate entries and drain in program order.
REQ-030 SHALL compute ld_hit/ld_data, st_ready and dm_* purely combinationally from current state and inputs (zero latency).
REQ-031 SHALL use a count width sufficient to represent DEPTH; count never exceeds DEPTH nor goes below 0.

Reset
REQ-032 SHALL on reset=0 immediately clear head, tail, count to 0 and invalidate all entries, independent of clk.
REQ-033 SHALL while reset=0 drive dm_we=0, dm_addr=dm_wd=dm_pc=0, count=0, empty=1, st_ready=1, ld_hit=0, ld_data=dm_rd.
REQ-034 SHALL discard in-flight stores on reset mid-operation; no dm_we after reset release until a new push.
REQ-035 SHALL resume normal operation on the first rising edge after reset returns to 1.

Verification
REQ-036 Push 0x0000_0010<=0xAAAA_0001 with drain_en=0 -> count=1, dm_we=0; raise drain_en -> dm_we=1, dm_addr=0x10, dm_wd=0xAAAA_0001 that cycle, count=0 next edge.
REQ-037 drain_en=0, push DEPTH=4 stores -> st_ready=0, fifth store with drain_en=1 same cycle refused, count stays 3 after edge then accepts.
REQ-038 Push 0x20<=0x1111, then 0x20<=0x2222; ld_addr=0x23 -> ld_hit=1, ld_data=0x2222; drains in order 0x1111 then 0x2222.
REQ-039 ld_addr=0x40 with no match, dm_rd=0xDEAD_BEEF -> ld_hit=0, ld_data=0xDEAD_BEEF; push to 0x40 same cycle -> still miss, hit next cycle.
REQ-040 Fill 4, drain 2, push 2 more (tail wraps) -> drain order exactly matches push order, dm_pc matches each st_pc.
REQ-041 Assert reset=0 between clock edges with count=3 -> count=0, dm_we=0 immediately; after release no writes occur.
